cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 block downstream of the branch-delay/victim-PC latch.
- Consumes the latched victim PC and branch-delay flag, plus the pipeline exception code and hardware interrupt lines.
- Decides whether to take an interrupt or exception, records EPC/Cause/SR, and serves mfc0/mtc0/eret.
- Its int_req output flushes the pipeline and redirects fetch to the handler at 0x0000_4180.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception vector driven on handler_pc.
- PRID_VAL, 32'h0000_2019, read-only processor ID value.
- NUM_HWINT, 6, number of external interrupt lines (maps to Cause.IP[15:10]).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- pc_in  in  32  victim PC from the branch-delay latch.
- bd_in  in  1  victim instruction sits in a delay slot.
- exc_valid  in  1  the M-stage instruction raised a synchronous exception.
- exc_code  in  5  ExcCode for that exception.
- hw_int  in  NUM_HWINT  level-sensitive external interrupt lines.
- we  in  1  mtc0 write strobe.
- addr  in  5  CP0 register number for mfc0/mtc0.
- wdata  in  32  mtc0 data.
- eret  in  1  eret committing this cycle.
- rdata  out  32  mfc0 read data (combinational).
- epc_out  out  32  current EPC, used as the eret target.
- int_req  out  1  take exception/interrupt this cycle (combinational).
- handler_pc  out  32  constant HANDLER_PC.
- exl_out  out  1  SR.EXL.

Behaviour:
- Registers (others read 0, writes ignored):
  - SR (12): IM[15:10], EXL[1], IE[0].
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC (14).
  - PRId (15).
- Reset values: SR=0, Cause=0, EPC=0. rdata follows addr; int_req=0.
- Interrupt condition: irq = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- Exception condition: exc = exc_valid & ~SR.EXL.
- int_req = irq | exc. Interrupt has priority over a simultaneous exception.
- Cause.IP is sampled from hw_int every cycle, regardless of masking.
- On clk edge when int_req=1:
  - SR.EXL<=1.
  - Cause.BD<=bd_in.
  - Cause.ExcCode<= irq ? 0 : exc_code.
  - EPC<= bd_in ? {pc_in[31:2],2'b00}-4 : {pc_in[31:2],2'b00}.
  - mtc0 in the same cycle is discarded.
- eret (int_req=0): SR.EXL<=0 on the next edge; EPC is unchanged.
- Simultaneous eret and int_req: int_req wins and the eret is ignored.
- mtc0 (we=1, int_req=0):
  - addr 12: SR<=wdata masked to IM/EXL/IE.
  - addr 14: EPC<={wdata[31:2],2'b00}.
  - addr 13: only Cause bits [9:8] (software IP) are writable.
  - addr 15: ignored.
- mtc0 to SR with IE=1 makes an interrupt visible from the following cycle. There is no same-cycle bypass of SR into irq.
- Reset asserted mid-handler: all state clears immediately and int_req drops combinationally.
- EPC arithmetic is 32-bit modulo: pc 0x0000_0000 in a delay slot gives 0xFFFF_FFFC.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined:
  - Adds Count (9), free-running, +1 per clk, wrapping at 2^32.
  - Adds Compare (11).
  - When Count==Compare, sets Cause.IP[15] (a shared timer bit OR'd into IP[15]) until Compare is written.
  - Compare is masked by SR.IM[15].
  - Reset value of both registers is 0.
  - mtc0 to Count sets it, and it resumes incrementing next cycle.
- Undefined: addresses 9 and 11 read 0 and writes are ignored; IP[15] reflects hw_int[5] only.

Decomposition:
- Package cp0_pkg:
  - Register index constants: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_COUNT=9, CP0_COMPARE=11.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause writable-bit masks.
- Sub-module cp0_timer (Count/Compare plus timer-pending flag), instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset pulse low -> rdata at addr 12/13/14 = 0; int_req=0; PRId reads 0x0000_2019.
- mtc0 SR=0x0000_0401, then hw_int=6'b000001 -> int_req=1 next cycle.
  - With pc_in=0x3008, bd_in=0, after the edge: EPC=0x3008, ExcCode=0, EXL=1, int_req=0.
- exc_valid=1, exc_code=12, pc_in=0x3010, bd_in=1 -> EPC=0x300C, Cause.BD=1, Cause[6:2]=12.
- hw_int pending and exc_valid in the same cycle -> ExcCode=0 (interrupt wins).
  - Then eret -> EXL=0 and epc_out unchanged.
- EXL=1 with exc_valid=1 -> int_req=0 and EPC unchanged. Also, mtc0 EPC=0x3003 -> reads 0x3000.
- CP0_TIMER_EN defined: Compare=5, SR=0x8001 -> int_req asserts when Count reaches 5, and writing Compare clears the pending bit.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes, writable-bit masks and the
// EPC alignment helper shared by the CP0 unit and its timer.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } excCode_e;

    // SR keeps IM[15:10], EXL[1], IE[0]; software can only touch Cause.IP[9:8]
    localparam logic [31:0] SR_WMASK    = 32'h0000_FC03;
    localparam logic [31:0] CAUSE_WMASK = 32'h0000_0300;
    localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

    // Word-aligned victim PC, backed up one instruction when it sits in a delay slot
    function automatic logic [31:0] epcOf(input logic [31:0] pc, input logic bd);
        logic [31:0] aligned;
        aligned = pc & WORD_MASK;
        return bd ? aligned - 32'd4 : aligned;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-pending flag.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        countWe_i,
    input  logic        compareWe_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timerIrq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;
    logic        match;

    assign match      = (count_q == compare_q);
    assign timerIrq_o = pending_q | match;
    assign count_o    = count_q;
    assign compare_o  = compare_q;

    // Count ticks every cycle unless overwritten; a Compare write re-arms the flag
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        pending_d = pending_q | match;
        if (countWe_i) begin
            count_d = wdata_i;
        end
        if (compareWe_i) begin
            compare_d = wdata_i;
            pending_d = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            compare_q <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 exception/interrupt decision plus SR/Cause/EPC/PRId
// access for mfc0/mtc0/eret. Define CP0_TIMER_EN to add Count/Compare.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_2019,
    parameter int          NUM_HWINT  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_in,
    input  logic                 bd_in,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    input  logic                 eret,
    output logic [31:0]          rdata,
    output logic [31:0]          epc_out,
    output logic                 int_req,
    output logic [31:0]          handler_pc,
    output logic                 exl_out
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  hwLines;
    logic [5:0]  irqLines;
    logic        timerIrq;
    logic        irq;
    logic        exc;

`ifdef CP0_TIMER_EN
    logic [31:0] timerCount;
    logic [31:0] timerCompare;

    cp0_timer uTimer (
        .clk_i       (clk),
        .rst_ni      (reset),
        .countWe_i   (we && !int_req && (addr == CP0_COUNT)),
        .compareWe_i (we && !int_req && (addr == CP0_COMPARE)),
        .wdata_i     (wdata),
        .count_o     (timerCount),
        .compare_o   (timerCompare),
        .timerIrq_o  (timerIrq)
    );
`else
    assign timerIrq = 1'b0;
`endif

    assign hwLines    = 6'(hw_int);
    assign irqLines   = hwLines | {timerIrq, 5'b0};
    assign irq        = (|(irqLines & sr_q[15:10])) & sr_q[0] & ~sr_q[1];
    assign exc        = exc_valid & ~sr_q[1];
    assign int_req    = reset & (irq | exc);
    assign epc_out    = epc_q;
    assign exl_out    = sr_q[1];
    assign handler_pc = HANDLER_PC;

    // Trap entry beats eret and mtc0; Cause.IP tracks the raw lines every cycle
    always_comb begin
        sr_d             = sr_q;
        cause_d          = cause_q;
        epc_d            = epc_q;
        cause_d[15:10]   = hwLines;
        if (int_req) begin
            sr_d[1]      = 1'b1;
            cause_d[31]  = bd_in;
            cause_d[6:2] = irq ? 5'(EXC_INT) : exc_code;
            epc_d        = epcOf(pc_in, bd_in);
        end else begin
            if (we) begin
                case (addr)
                    CP0_SR:    sr_d    = wdata & SR_WMASK;
                    CP0_CAUSE: cause_d = (cause_d & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
                    CP0_EPC:   epc_d   = wdata & WORD_MASK;
                    default:   ;
                endcase
            end
            if (eret) begin
                sr_d[1] = 1'b0;
            end
        end
    end

    // CP0 architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // mfc0 read mux; the timer flag is folded into Cause.IP[15] on the way out
    always_comb begin
        rdata = '0;
        case (addr)
            CP0_SR:      rdata = sr_q;
            CP0_CAUSE:   rdata = cause_q | {16'b0, timerIrq, 15'b0};
            CP0_EPC:     rdata = epc_q;
            CP0_PRID:    rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rdata = timerCount;
            CP0_COMPARE: rdata = timerCompare;
`endif
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: table-driven directed vectors for cp0_unit plus hand-written
// sequences for async reset mid-handler and (with CP0_TIMER_EN) the timer.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        bd_in;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        int_req;
    logic [31:0] handler_pc;
    logic        exl_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [5:0]  hw;
        logic        excV;
        logic [4:0]  excC;
        logic [31:0] pc;
        logic        bd;
        logic        eret;
        logic        expInt;
        logic [31:0] expRdata;
        logic [31:0] expEpc;
        logic        expExl;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    cp0_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .bd_in      (bd_in),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .eret       (eret),
        .rdata      (rdata),
        .epc_out    (epc_out),
        .int_req    (int_req),
        .handler_pc (handler_pc),
        .exl_out    (exl_out)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string what, input int idx,
                               input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s #%0d: got %h, want %h", what, idx, got, want);
        end
    endtask

    // Drive one vector on the falling edge and let combinational outputs settle
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        we        = v.we;
        addr      = v.addr;
        wdata     = v.wdata;
        hw_int    = v.hw;
        exc_valid = v.excV;
        exc_code  = v.excC;
        pc_in     = v.pc;
        bd_in     = v.bd;
        eret      = v.eret;
        #1;
    endtask

    // Single-cycle mtc0 helper for the hand-written sequences
    task automatic writeCp0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    initial begin
        bit seen;

        //                we    addr   wdata         hw     excV  excC   pc            bd    eret  | int   rdata         epc           exl
        vecs[0]  = '{1'b0, 5'd12, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 5'd13, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 5'd14, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 5'd15, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h2019,     32'h0,        1'b0};
        vecs[4]  = '{1'b1, 5'd3,  32'hFFFFFFFF, 6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1, 5'd12, 32'hFFFF07FD, 6'h01, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b0, 5'd12, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h401,      32'h0,        1'b0};
        vecs[7]  = '{1'b0, 5'd12, 32'h0,        6'h01, 1'b0, 5'd0,  32'h3008,     1'b0, 1'b0, 1'b1, 32'h401,      32'h0,        1'b0};
        vecs[8]  = '{1'b0, 5'd13, 32'h0,        6'h01, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h400,      32'h3008,     1'b1};
        vecs[9]  = '{1'b0, 5'd12, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h403,      32'h3008,     1'b1};
        vecs[10] = '{1'b0, 5'd14, 32'h0,        6'h00, 1'b1, 5'd12, 32'h5000,     1'b0, 1'b0, 1'b0, 32'h3008,     32'h3008,     1'b1};
        vecs[11] = '{1'b0, 5'd14, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h3008,     32'h3008,     1'b1};
        vecs[12] = '{1'b1, 5'd12, 32'h0,        6'h00, 1'b1, 5'd12, 32'h3010,     1'b1, 1'b0, 1'b1, 32'h401,      32'h3008,     1'b0};
        vecs[13] = '{1'b0, 5'd13, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h80000030, 32'h300C,     1'b1};
        vecs[14] = '{1'b0, 5'd12, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h403,      32'h300C,     1'b1};
        vecs[15] = '{1'b0, 5'd14, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h300C,     32'h300C,     1'b1};
        vecs[16] = '{1'b0, 5'd13, 32'h0,        6'h01, 1'b1, 5'd4,  32'h4000,     1'b0, 1'b1, 1'b1, 32'h80000030, 32'h300C,     1'b0};
        vecs[17] = '{1'b0, 5'd13, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h400,      32'h4000,     1'b1};
        vecs[18] = '{1'b0, 5'd14, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h4000,     32'h4000,     1'b1};
        vecs[19] = '{1'b1, 5'd14, 32'h3003,     6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h4000,     32'h4000,     1'b0};
        vecs[20] = '{1'b0, 5'd14, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h3000,     32'h3000,     1'b0};
        vecs[21] = '{1'b1, 5'd13, 32'hFFFFFFFF, 6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h3000,     1'b0};
        vecs[22] = '{1'b0, 5'd13, 32'h0,        6'h20, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h300,      32'h3000,     1'b0};
        vecs[23] = '{1'b0, 5'd13, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h8300,     32'h3000,     1'b0};
        vecs[24] = '{1'b1, 5'd12, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h401,      32'h3000,     1'b0};
        vecs[25] = '{1'b0, 5'd12, 32'h0,        6'h00, 1'b1, 5'd5,  32'h00000002, 1'b1, 1'b0, 1'b1, 32'h0,        32'h3000,     1'b0};
        vecs[26] = '{1'b0, 5'd14, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1};
        vecs[27] = '{1'b0, 5'd13, 32'h0,        6'h00, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h80000314, 32'hFFFFFFFC, 1'b1};

        reset     = 1'b0;
        we        = 1'b0;
        addr      = 5'd0;
        wdata     = 32'h0;
        hw_int    = 6'h00;
        exc_valid = 1'b0;
        exc_code  = 5'd0;
        pc_in     = 32'h0;
        bd_in     = 1'b0;
        eret      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("int_req in reset", 0, {31'b0, int_req}, 32'h0);
        reset = 1'b1;

        checkOutput("handler_pc", 0, handler_pc, 32'h0000_4180);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput("int_req", i, {31'b0, int_req}, {31'b0, vecs[i].expInt});
            checkOutput("rdata",   i, rdata, vecs[i].expRdata);
            checkOutput("epc_out", i, epc_out, vecs[i].expEpc);
            checkOutput("exl_out", i, {31'b0, exl_out}, {31'b0, vecs[i].expExl});
        end

        // Reset dropped mid-handler: exception pending, then async clear
        @(negedge clk);
        we        = 1'b0;
        addr      = 5'd12;
        eret      = 1'b1;
        @(negedge clk);
        eret      = 1'b0;
        exc_valid = 1'b1;
        exc_code  = 5'd10;
        pc_in     = 32'h100;
        #1;
        checkOutput("int_req before reset", 100, {31'b0, int_req}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("int_req in reset", 101, {31'b0, int_req}, 32'h0);
        checkOutput("exl_out in reset", 101, {31'b0, exl_out}, 32'h0);
        checkOutput("epc_out in reset", 101, epc_out, 32'h0);
        checkOutput("SR in reset",      101, rdata, 32'h0);
        exc_valid = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);
        addr = 5'd13;
        #1;
        checkOutput("Cause after reset", 102, rdata, 32'h0);

`ifdef CP0_TIMER_EN
        // Timer: Compare=5, SR=0x8001, Count restarted at 0
        writeCp0(5'd9, 32'd1000);
        writeCp0(5'd11, 32'd5);
        writeCp0(5'd12, 32'h8001);
        writeCp0(5'd9, 32'd0);
        addr = 5'd9;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (int_req) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("timer int_req", 200, {31'b0, seen}, 32'h1);
        checkOutput("count at timer irq", 200, rdata, 32'd5);
        @(negedge clk);
        addr = 5'd13;
        #1;
        checkOutput("timer IP15 pending", 201, rdata & 32'h8000, 32'h8000);
        writeCp0(5'd11, 32'd1000);
        addr = 5'd13;
        #1;
        checkOutput("timer IP15 cleared", 202, rdata & 32'h8000, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
